// File: rtl/sha2_msg_padder.sv
// SHA-2 message padder: packs a byte stream into 16-word blocks, appends the
// 0x80 marker, zero fill and the big-endian message bit length.
`timescale 1ns/1ps
module sha2_msg_padder #(
    parameter int WORDSIZE = 32
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [7:0]              i_in_data,
    input  logic                    i_in_valid,
    input  logic                    i_in_last,
    output logic                    o_in_ready,
    output logic [WORDSIZE*16-1:0]  o_m,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic                    o_m_first,
    output logic                    o_m_last
);
    localparam int BB = 2 * WORDSIZE;
    localparam int LB = WORDSIZE / 4;
    localparam int IW = $clog2(BB);
    localparam int LW = 2 * WORDSIZE;

    typedef enum logic [1:0] {ST_ABSORB, ST_PAD, ST_LEN, ST_EMIT} state_t;

    state_t          r_state, w_state_next;
    state_t          r_ret, w_ret_next;
    logic [BB*8-1:0] r_buf, w_buf_next;
    logic [IW-1:0]   r_idx;
    logic [LW-1:0]   r_len;
    logic            r_final;
    logic            r_first;
    logic            w_accept;
    logic            w_idx_last;
    logic            w_len_fits;

    assign w_accept   = (r_state == ST_ABSORB) && i_in_valid;
    assign w_idx_last = (r_idx == IW'(BB - 1));
    assign w_len_fits = (r_idx <= IW'(BB - LB - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_ABSORB;
            r_ret   <= ST_ABSORB;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        unique case (r_state)
            ST_ABSORB: begin
                if (w_accept) begin
                    if (w_idx_last) begin
                        w_state_next = ST_EMIT;
                        w_ret_next   = i_in_last ? ST_PAD : ST_ABSORB;
                    end else if (i_in_last) begin
                        w_state_next = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_state_next = ST_EMIT;
                w_ret_next   = w_len_fits ? ST_ABSORB : ST_LEN;
            end
            ST_LEN: begin
                w_state_next = ST_EMIT;
                w_ret_next   = ST_ABSORB;
            end
            ST_EMIT: begin
                if (i_m_ready) w_state_next = r_ret;
            end
            default: w_state_next = ST_ABSORB;
        endcase
    end

    // Byte gi sits at o_m[(BB-gi)*8-1 -: 8]; the length field is the low LW bits.
    for (genvar gi = 0; gi < BB; gi++) begin : g_byte
        localparam int HI = (BB - gi) * 8 - 1;
        logic [7:0] w_len_byte;
        logic [7:0] w_byte;

        if (gi >= BB - LB) begin : g_len
            assign w_len_byte = r_len[(BB-1-gi)*8 +: 8];
        end else begin : g_data
            assign w_len_byte = 8'h00;
        end

        always_comb begin
            w_byte = r_buf[HI -: 8];
            case (r_state)
                ST_ABSORB: if (w_accept && (r_idx == IW'(gi))) w_byte = i_in_data;
                ST_PAD: begin
                    if (r_idx == IW'(gi))
                        w_byte = 8'h80;
                    else if (IW'(gi) > r_idx)
                        w_byte = w_len_fits ? w_len_byte : 8'h00;
                end
                ST_LEN:  w_byte = w_len_byte;
                default: w_byte = r_buf[HI -: 8];
            endcase
        end

        assign w_buf_next[HI -: 8] = w_byte;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_final <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_buf <= w_buf_next;
            case (r_state)
                ST_ABSORB: begin
                    if (w_accept) begin
                        r_idx <= r_idx + IW'(1);
                        r_len <= r_len + LW'(8);
                    end
                end
                ST_PAD: if (w_len_fits) r_final <= 1'b1;
                ST_LEN: r_final <= 1'b1;
                ST_EMIT: begin
                    if (i_m_ready) begin
                        r_idx   <= '0;
                        r_first <= r_final;
                        if (r_final) begin
                            r_len   <= '0;
                            r_final <= 1'b0;
                        end
                    end
                end
                default: r_idx <= r_idx;
            endcase
        end
    end

    assign o_in_ready = (r_state == ST_ABSORB) && !srst;
    assign o_m        = r_buf;
    assign o_m_valid  = (r_state == ST_EMIT);
    assign o_m_first  = (r_state == ST_EMIT) && r_first;
    assign o_m_last   = (r_state == ST_EMIT) && r_final;
endmodule
